// File: rtl/oscu_addr_sequencer_pkg.sv
// rtl/oscu_addr_sequencer_pkg.sv - shared widths, limits and state encoding for the OSCU address sequencer
package oscu_seq_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DIV_W_DEF  = 8;
  localparam int MAX_LEN    = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/oscu_addr_sequencer_tick_gen.sv
// rtl/oscu_addr_sequencer_tick_gen.sv - pacing prescaler producing one tick every div+1 enabled cycles
module oscu_tick_gen
  import oscu_seq_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  assign w_hit  = (r_cnt == i_div);
  assign o_tick = i_en & w_hit;

  // Count 0..div while enabled, wrapping to 0 on the tick; clr restarts the period.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/oscu_addr_sequencer.sv
// rtl/oscu_addr_sequencer.sv - accepts scan commands and paces the OSCU address counter through a range
module oscu_addr_sequencer
  import oscu_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk2,
  input  logic              Reset,
  input  logic              Cmd_Valid,
  output logic              Cmd_Ready,
  input  logic [ADDR_W-1:0] Cmd_Start,
  input  logic [ADDR_W:0]   Cmd_Length,
  input  logic [DIV_W-1:0]  Rate_Div,
  input  logic              Abort,
  input  logic              AddTimer_Rollover,
  input  logic [ADDR_W-1:0] CurrentAdd,
  output logic              clear,
  output logic [ADDR_W-1:0] startvalue,
  output logic [ADDR_W-1:0] Rollover_Value,
  output logic              AddTimer_Ena,
  output logic              Addr_Strobe,
  output logic              Busy,
  output logic              Done,
  output logic              Cmd_Err
);

  // One past the highest address: start+length may reach this but not exceed it.
  localparam logic [ADDR_W+1:0] LP_ADDR_SPAN = {2'b01, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LP_REM_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  seq_state_e        r_state;
  logic [ADDR_W-1:0] r_start;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W:0]   r_remaining;
  logic [DIV_W-1:0]  r_div;
  logic              r_clear;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W+1:0] w_sum;
  logic              w_bad_cmd;
  logic              w_accept;
  logic              w_active;
  logic              w_abort;
  logic              w_tick;
  logic              w_step;
  logic              w_more;
  logic              w_end_ok;

  assign w_sum     = {2'b00, Cmd_Start} + {1'b0, Cmd_Length};
  assign w_bad_cmd = (Cmd_Length == '0) || (w_sum > LP_ADDR_SPAN);
  assign w_accept  = Cmd_Valid & Cmd_Ready;

  assign w_active  = (r_state == LOAD) || (r_state == RUN);
  assign w_abort   = Abort & w_active;

  // Abort wins over a tick in the same cycle: no strobe, no increment.
  assign w_step    = w_tick & ~Abort;
  assign w_more    = (r_remaining > LP_REM_ONE);

  // The counter must sit on the terminal address when the last strobe goes out.
  assign w_end_ok  = AddTimer_Rollover && (CurrentAdd == r_end);

  oscu_tick_gen #(
    .DIV_W (DIV_W)
  ) u_tick_gen (
    .clk    (clk2),
    .rst    (Reset),
    .i_clr  (r_state == LOAD),
    .i_en   (r_state == RUN),
    .i_div  (r_div),
    .o_tick (w_tick)
  );

  assign Cmd_Ready      = (r_state == IDLE) & ~Reset;
  assign clear          = r_clear;
  assign startvalue     = r_start;
  assign Rollover_Value = r_end;
  assign Addr_Strobe    = w_step;
  assign AddTimer_Ena   = w_step & w_more;
  assign Busy           = r_busy;
  assign Done           = r_done;
  assign Cmd_Err        = r_err;

  // Scan control: accept/reject, one-cycle counter load, paced run, completion and abort.
  always_ff @(posedge clk2) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_start     <= '0;
      r_end       <= '0;
      r_remaining <= '0;
      r_div       <= '0;
      r_clear     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_bad_cmd) begin
              r_err <= 1'b1;
            end else begin
              r_start     <= Cmd_Start;
              r_end       <= Cmd_Start + Cmd_Length[ADDR_W-1:0] - 1'b1;
              r_remaining <= Cmd_Length;
              r_div       <= Rate_Div;
              r_clear     <= 1'b1;
              r_busy      <= 1'b1;
              r_state     <= LOAD;
            end
          end
        end
        LOAD: begin
          r_clear <= 1'b0;
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_state <= RUN;
          end
        end
        RUN: begin
          if (w_abort) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_tick) begin
            if (w_more) begin
              r_remaining <= r_remaining - 1'b1;
            end else begin
              r_remaining <= '0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
              r_err       <= ~w_end_ok;
              r_state     <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_clear <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oscu_addr_sequencer.sv
// tb/tb_oscu_addr_sequencer.sv - randomized self-checking bench for oscu_addr_sequencer
module tb_oscu_addr_sequencer;

  logic       clk2 = 1'b0;
  logic       Reset;
  logic       Cmd_Valid;
  logic       Cmd_Ready;
  logic [6:0] Cmd_Start;
  logic [7:0] Cmd_Length;
  logic [7:0] Rate_Div;
  logic       Abort;
  logic       AddTimer_Rollover;
  logic [6:0] CurrentAdd;
  logic       clear;
  logic [6:0] startvalue;
  logic [6:0] Rollover_Value;
  logic       AddTimer_Ena;
  logic       Addr_Strobe;
  logic       Busy;
  logic       Done;
  logic       Cmd_Err;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] cnt_model;
  bit         freeze_cnt = 1'b0;

  always #5 clk2 = ~clk2;

  oscu_addr_sequencer dut (
    .clk2              (clk2),
    .Reset             (Reset),
    .Cmd_Valid         (Cmd_Valid),
    .Cmd_Ready         (Cmd_Ready),
    .Cmd_Start         (Cmd_Start),
    .Cmd_Length        (Cmd_Length),
    .Rate_Div          (Rate_Div),
    .Abort             (Abort),
    .AddTimer_Rollover (AddTimer_Rollover),
    .CurrentAdd        (CurrentAdd),
    .clear             (clear),
    .startvalue        (startvalue),
    .Rollover_Value    (Rollover_Value),
    .AddTimer_Ena      (AddTimer_Ena),
    .Addr_Strobe       (Addr_Strobe),
    .Busy              (Busy),
    .Done              (Done),
    .Cmd_Err           (Cmd_Err)
  );

  // Behavioural address counter the sequencer drives; freeze_cnt models a stuck counter.
  always @(posedge clk2) begin
    if (clear) cnt_model <= startvalue;
    else if (AddTimer_Ena && !freeze_cnt) cnt_model <= cnt_model + 7'd1;
  end
  assign CurrentAdd        = cnt_model;
  assign AddTimer_Rollover = (cnt_model == Rollover_Value);

  function automatic logic [6:0] outs();
    return {Cmd_Ready, clear, Busy, Addr_Strobe, AddTimer_Ena, Done, Cmd_Err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected behaviour from the scan rules: strobe k (1-based) lands in cycle k*(div+1)+1
  // after the accepting edge, last strobe closes Busy, Done follows one cycle later.
  task automatic run_scan(input int start, input int len, input int div, input int ka, input bit fault);
    int period, t_last, t_a, t_end, k;
    bit is_str, aborted, e_ready, e_clear, e_busy, e_str, e_ena, e_done, e_err;
    Cmd_Valid  = 1'b1;
    Cmd_Start  = 7'(start);
    Cmd_Length = 8'(len);
    Rate_Div   = 8'(div);
    freeze_cnt = fault;
    @(negedge clk2);
    check("ready_pre", 32'(Cmd_Ready), 32'd1);
    @(posedge clk2); #1;
    Cmd_Valid = 1'b0;
    period = div + 1;
    t_last = len * period + 1;
    t_a    = (ka != 0) ? ka * period + 1 : 0;
    t_end  = (ka != 0) ? t_a + 1 : t_last + 2;
    for (int t = 1; t <= t_end; t++) begin
      // Abort is driven on the chosen strobe, and also in DONE/IDLE where it must be ignored.
      Abort      = (t == t_a) || ((ka == 0) && (t >= t_last + 1));
      Rate_Div   = 8'($urandom);
      Cmd_Start  = 7'($urandom);
      Cmd_Length = 8'($urandom);
      k       = (t - 1) / period;
      is_str  = (t >= 2) && ((t - 1) % period == 0) && (k >= 1) && (k <= len);
      aborted = (ka != 0) && (t > t_a);
      e_str   = is_str && !(t == t_a) && !aborted;
      e_ena   = e_str && (k < len);
      e_clear = (t == 1);
      e_busy  = (t <= t_last) && !aborted;
      e_done  = (ka == 0) && (t == t_last + 1);
      e_err   = fault && (t == t_last + 1);
      e_ready = aborted || (t >= t_last + 2);
      @(negedge clk2);
      check($sformatf("outs s%0d l%0d d%0d t%0d", start, len, div, t), 32'(outs()),
            32'({e_ready, e_clear, e_busy, e_str, e_ena, e_done, e_err}));
      if (e_str && !fault) check($sformatf("addr k%0d", k), 32'(CurrentAdd), 32'((start + k - 1) & 127));
      if (t == 1) begin
        check("startvalue", 32'(startvalue), 32'(start));
        check("rollover_value", 32'(Rollover_Value), 32'(start + len - 1));
      end
      @(posedge clk2); #1;
    end
    Abort      = 1'b0;
    freeze_cnt = 1'b0;
  endtask

  task automatic reject(input int start, input int len);
    Cmd_Valid  = 1'b1;
    Cmd_Start  = 7'(start);
    Cmd_Length = 8'(len);
    Rate_Div   = 8'($urandom);
    @(negedge clk2);
    check("rej_ready_pre", 32'(Cmd_Ready), 32'd1);
    @(posedge clk2); #1;
    Cmd_Valid = 1'b0;
    @(negedge clk2);
    check($sformatf("rej_err s%0d l%0d", start, len), 32'(outs()), 32'(7'b1000001));
    @(posedge clk2); #1;
    @(negedge clk2);
    check("rej_after", 32'(outs()), 32'(7'b1000000));
    @(posedge clk2); #1;
  endtask

  initial begin
    int s, l, d, ka;
    Reset      = 1'b1;
    Cmd_Valid  = 1'b0;
    Cmd_Start  = '0;
    Cmd_Length = '0;
    Rate_Div   = '0;
    Abort      = 1'b0;
    repeat (3) @(posedge clk2);
    #1;
    @(negedge clk2);
    check("reset_outs", 32'(outs()), 32'd0);
    check("reset_startvalue", 32'(startvalue), 32'd0);
    check("reset_rollover_value", 32'(Rollover_Value), 32'd0);
    @(posedge clk2); #1;
    Reset = 1'b0;
    @(negedge clk2);
    check("ready_after_reset", 32'(outs()), 32'(7'b1000000));
    @(posedge clk2); #1;

    run_scan(10, 4, 0, 0, 1'b0);
    run_scan(0, 2, 3, 0, 1'b0);
    reject(120, 9);
    reject(5, 0);
    run_scan(0, 128, 0, 0, 1'b0);
    run_scan(5, 10, 1, 3, 1'b0);
    run_scan(40, 1, 2, 0, 1'b0);
    run_scan(7, 3, 2, 0, 1'b1);
    run_scan(127, 1, 0, 0, 1'b0);

    // Reset in the middle of a run.
    Cmd_Valid  = 1'b1;
    Cmd_Start  = 7'd20;
    Cmd_Length = 8'd10;
    Rate_Div   = 8'd2;
    @(posedge clk2); #1;
    Cmd_Valid = 1'b0;
    repeat (8) begin
      @(posedge clk2); #1;
    end
    Reset = 1'b1;
    @(posedge clk2); #1;
    @(negedge clk2);
    check("midrun_reset_outs", 32'(outs()), 32'd0);
    check("midrun_reset_startvalue", 32'(startvalue), 32'd0);
    check("midrun_reset_rollover", 32'(Rollover_Value), 32'd0);
    @(posedge clk2); #1;
    Reset = 1'b0;
    @(negedge clk2);
    check("midrun_reset_ready", 32'(outs()), 32'(7'b1000000));
    @(posedge clk2); #1;
    run_scan(3, 1, $urandom_range(0, 3), 0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      s  = $urandom_range(0, 127);
      l  = $urandom_range(1, 128 - s);
      d  = $urandom_range(0, 3);
      ka = ($urandom_range(0, 2) == 0) ? $urandom_range(1, l) : 0;
      run_scan(s, l, d, ka, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(1, 127);
        reject(s, $urandom_range(129 - s, 128));
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
